// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator: each channel pulses cen at refclk*NUM/DEN.
// Latency: cen is registered; a channel first accumulates on the edge after its locked flag rises.
// Backpressure: cfg_ready is high only in IDLE; held requests are accepted once settling finishes.
module clk_enable_gen #(
    parameter int                          CHANNELS    = 2,
    parameter int                          ACC_W       = 16,
    parameter int                          LOCK_CYCLES = 256,
    parameter logic [CHANNELS*ACC_W-1:0]   DEF_NUM     = {16'd1, 16'd1},
    parameter logic [CHANNELS*ACC_W-1:0]   DEF_DEN     = {16'd1, 16'd8}
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_chan,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den,
    input  logic [ACC_W-1:0]    cfg_phase,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] cen,
    output logic [CHANNELS-1:0] locked
);

    localparam int              CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] target_q, target_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [CHANNELS-1:0] cen_q, cen_d;
    logic [CHANNELS-1:0] locked_q, locked_d;
    logic [ACC_W-1:0]    num_q [CHANNELS];
    logic [ACC_W-1:0]    num_d [CHANNELS];
    logic [ACC_W-1:0]    den_q [CHANNELS];
    logic [ACC_W-1:0]    den_d [CHANNELS];
    logic [ACC_W-1:0]    acc_q [CHANNELS];
    logic [ACC_W-1:0]    acc_d [CHANNELS];

    logic                cfg_fire;
    logic                cfg_bad;
    logic                cfg_load;
    logic [CHANNELS-1:0] sel;
    logic                settle_done;

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign cen       = cen_q;
    assign locked    = locked_q;

    // Request decode: a handshake either loads one channel or is rejected outright.
    always_comb begin
        cfg_fire = cfg_valid & ready_q;
        cfg_bad  = (int'(cfg_chan) >= CHANNELS) || (cfg_den == '0) ||
                   (cfg_num > cfg_den) || (cfg_phase >= cfg_den);
        cfg_load = cfg_fire & ~cfg_bad;
        sel      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel[i] = cfg_load && (cfg_chan == 3'(i));
        end
    end

    // Next-state logic: IDLE waits for a valid request, SETTLE counts down to lock.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        target_d    = target_q;
        settle_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    state_d  = SETTLE;
                    cnt_d    = CNT_INIT;
                    target_d = sel;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    settle_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs: ready returns with settle completion, error is a single-cycle pulse.
    always_comb begin
        ready_d = ready_q;
        if (settle_done) begin
            ready_d = 1'b1;
        end else if (cfg_load) begin
            ready_d = 1'b0;
        end
        err_d = cfg_fire & cfg_bad;
    end

    // Per-channel accumulators: locked channels step; a selected channel reloads and unlocks.
    always_comb begin
        logic [ACC_W:0] sum;
        sum      = '0;
        cen_d    = '0;
        locked_d = locked_q;
        num_d    = num_q;
        den_d    = den_q;
        acc_d    = acc_q;
        for (int i = 0; i < CHANNELS; i++) begin
            // One extra bit so acc + num never wraps before the compare.
            sum = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
            if (locked_q[i]) begin
                if (sum >= {1'b0, den_q[i]}) begin
                    acc_d[i] = ACC_W'(sum - {1'b0, den_q[i]});
                    cen_d[i] = 1'b1;
                end else begin
                    acc_d[i] = sum[ACC_W-1:0];
                end
            end
            if (sel[i]) begin
                num_d[i]    = cfg_num;
                den_d[i]    = cfg_den;
                acc_d[i]    = cfg_phase;
                cen_d[i]    = 1'b0;
                locked_d[i] = 1'b0;
            end
            if (settle_done && target_q[i]) begin
                locked_d[i] = 1'b1;
            end
        end
    end

    // State register with synchronous reset to the default rates and a full-chip settle.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= SETTLE;
            cnt_q    <= CNT_INIT;
            target_q <= '1;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            cen_q    <= '0;
            locked_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                num_q[i] <= DEF_NUM[i*ACC_W +: ACC_W];
                den_q[i] <= DEF_DEN[i*ACC_W +: ACC_W];
                acc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            cen_q    <= cen_d;
            locked_q <= locked_d;
            num_q    <= num_d;
            den_q    <= den_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen with two channels and a short settle time.
// Expected outputs come from a closed-form pulse model queued ahead of each edge.
// A monitor pops one expectation per edge; scenario tasks add their own targeted checks.
module tb_clk_enable_gen;

    localparam int LC = 4;

    logic        refclk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_chan;
    logic [15:0] cfg_num;
    logic [15:0] cfg_den;
    logic [15:0] cfg_phase;
    logic        cfg_err;
    logic [1:0]  cen;
    logic [1:0]  locked;

    clk_enable_gen #(
        .CHANNELS(2),
        .ACC_W(16),
        .LOCK_CYCLES(LC)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan),
        .cfg_num(cfg_num),
        .cfg_den(cfg_den),
        .cfg_phase(cfg_phase),
        .cfg_err(cfg_err),
        .cen(cen),
        .locked(locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct packed {
        logic [1:0] cen;
        logic [1:0] lk;
        logic       rdy;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt0     = 0;

    // Reference model state
    longint     m_num [2];
    longint     m_den [2];
    longint     m_ph  [2];
    longint     m_k   [2];
    logic [1:0] m_locked = 2'b00;
    logic [1:0] m_cen    = 2'b00;
    logic [1:0] m_target = 2'b00;
    logic       m_ready  = 1'b0;
    logic       m_err    = 1'b0;
    int         m_settle = 0;

    // Scoreboard consumer: one expectation per edge, compared just after the edge.
    always @(posedge refclk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks += 4;
            if (cen !== e.cen) begin
                n_errors++;
                $display("FAIL sb_cen t=%0t got=%b exp=%b", $time, cen, e.cen);
            end
            if (locked !== e.lk) begin
                n_errors++;
                $display("FAIL sb_locked t=%0t got=%b exp=%b", $time, locked, e.lk);
            end
            if (cfg_ready !== e.rdy) begin
                n_errors++;
                $display("FAIL sb_ready t=%0t got=%b exp=%b", $time, cfg_ready, e.rdy);
            end
            if (cfg_err !== e.err) begin
                n_errors++;
                $display("FAIL sb_err t=%0t got=%b exp=%b", $time, cfg_err, e.err);
            end
            if (cen[0] === 1'b1) cnt0++;
        end
    end

    // Advance the model over the coming edge using the driven inputs, queue it, take the edge.
    task automatic cycle();
        exp_t x;
        int   c;
        if (rst) begin
            m_num[0] = 1; m_den[0] = 8;
            m_num[1] = 1; m_den[1] = 1;
            for (int i = 0; i < 2; i++) begin
                m_ph[i] = 0;
                m_k[i]  = 0;
            end
            m_locked = 2'b00;
            m_cen    = 2'b00;
            m_ready  = 1'b0;
            m_err    = 1'b0;
            m_settle = LC;
            m_target = 2'b11;
        end else begin
            m_err = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (m_locked[i]) begin
                    m_k[i]++;
                    m_cen[i] = ((m_ph[i] + m_k[i] * m_num[i]) / m_den[i]) !=
                               ((m_ph[i] + (m_k[i] - 1) * m_num[i]) / m_den[i]);
                end else begin
                    m_cen[i] = 1'b0;
                end
            end
            if (cfg_valid && m_ready) begin
                if (cfg_chan >= 3'd2 || cfg_den == 16'd0 || cfg_num > cfg_den || cfg_phase >= cfg_den) begin
                    m_err = 1'b1;
                end else begin
                    c = int'(cfg_chan);
                    m_num[c]    = longint'(cfg_num);
                    m_den[c]    = longint'(cfg_den);
                    m_ph[c]     = longint'(cfg_phase);
                    m_k[c]      = 0;
                    m_locked[c] = 1'b0;
                    m_cen[c]    = 1'b0;
                    m_ready     = 1'b0;
                    m_settle    = LC;
                    m_target    = 2'b00;
                    m_target[c] = 1'b1;
                end
            end else if (m_settle > 0) begin
                m_settle--;
                if (m_settle == 0) begin
                    m_locked = m_locked | m_target;
                    m_ready  = 1'b1;
                end
            end
        end
        x.cen = m_cen;
        x.lk  = m_locked;
        x.rdy = m_ready;
        x.err = m_err;
        sb.push_back(x);
        @(posedge refclk);
        #2;
    endtask

    // Present a request and hold it until the DUT accepts it (bounded).
    task automatic do_cfg(input logic [2:0] ch, input logic [15:0] num,
                          input logic [15:0] den, input logic [15:0] ph);
        bit accepted;
        accepted  = 1'b0;
        cfg_chan  = ch;
        cfg_num   = num;
        cfg_den   = den;
        cfg_phase = ph;
        cfg_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cfg_ready === 1'b1) begin
                cycle();
                accepted = 1'b1;
                break;
            end
            cycle();
        end
        cfg_valid = 1'b0;
        n_checks++;
        if (!accepted) begin
            n_errors++;
            $display("FAIL cfg_accept_timeout got=0 exp=1");
        end
    endtask

    task automatic test_reset();
        int first;
        int n1;
        int snap;
        rst = 1'b1;
        repeat (3) cycle();
        n_checks += 4;
        if (cen !== 2'b00)     begin n_errors++; $display("FAIL rst_cen got=%b exp=00", cen); end
        if (locked !== 2'b00)  begin n_errors++; $display("FAIL rst_locked got=%b exp=00", locked); end
        if (cfg_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready got=%b exp=0", cfg_ready); end
        if (cfg_err !== 1'b0)  begin n_errors++; $display("FAIL rst_err got=%b exp=0", cfg_err); end
        rst = 1'b0;
        repeat (LC - 1) cycle();
        n_checks++;
        if (locked !== 2'b00) begin n_errors++; $display("FAIL pre_lock got=%b exp=00", locked); end
        cycle();
        n_checks += 2;
        if (locked !== 2'b11)   begin n_errors++; $display("FAIL lock_after_reset got=%b exp=11", locked); end
        if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL ready_after_reset got=%b exp=1", cfg_ready); end
        first = 0;
        n1    = 0;
        snap  = cnt0;
        for (int j = 1; j <= 24; j++) begin
            cycle();
            if (cen[1] === 1'b1) n1++;
            if (cen[0] === 1'b1 && first == 0) first = j;
        end
        n_checks += 3;
        if (n1 != 24)         begin n_errors++; $display("FAIL def_ch1_rate got=%0d exp=24", n1); end
        if (first != 8)       begin n_errors++; $display("FAIL def_ch0_first got=%0d exp=8", first); end
        if (cnt0 - snap != 3) begin n_errors++; $display("FAIL def_ch0_count got=%0d exp=3", cnt0 - snap); end
    endtask

    task automatic test_fractional();
        logic [6:0] pat;
        int snap;
        do_cfg(3'd0, 16'd3, 16'd7, 16'd0);
        repeat (LC) cycle();
        n_checks++;
        if (locked[0] !== 1'b1) begin n_errors++; $display("FAIL frac_lock got=%b exp=1", locked[0]); end
        pat  = '0;
        snap = cnt0;
        for (int j = 0; j < 700; j++) begin
            cycle();
            if (j < 7) pat[j] = cen[0];
        end
        n_checks += 2;
        if (pat !== 7'b1010100)  begin n_errors++; $display("FAIL frac_pattern got=%b exp=1010100", pat); end
        if (cnt0 - snap != 300)  begin n_errors++; $display("FAIL frac_count got=%0d exp=300", cnt0 - snap); end
    endtask

    task automatic test_phase();
        int first;
        int snap;
        logic [15:0] ph_tab [2];
        int          exp_first [2];
        ph_tab[0] = 16'd3; exp_first[0] = 1;
        ph_tab[1] = 16'd0; exp_first[1] = 4;
        for (int t = 0; t < 2; t++) begin
            do_cfg(3'd0, 16'd1, 16'd4, ph_tab[t]);
            repeat (LC) cycle();
            first = 0;
            snap  = cnt0;
            for (int j = 1; j <= 12; j++) begin
                cycle();
                if (cen[0] === 1'b1 && first == 0) first = j;
            end
            n_checks += 2;
            if (first != exp_first[t]) begin
                n_errors++;
                $display("FAIL phase_first ph=%0d got=%0d exp=%0d", ph_tab[t], first, exp_first[t]);
            end
            if (cnt0 - snap != 3) begin
                n_errors++;
                $display("FAIL phase_count ph=%0d got=%0d exp=3", ph_tab[t], cnt0 - snap);
            end
        end
    endtask

    task automatic test_rejects();
        logic [2:0]  ch_tab  [4];
        logic [15:0] num_tab [4];
        logic [15:0] den_tab [4];
        logic [15:0] ph_tab  [4];
        ch_tab[0] = 3'd0; num_tab[0] = 16'd1; den_tab[0] = 16'd0; ph_tab[0] = 16'd0;
        ch_tab[1] = 3'd0; num_tab[1] = 16'd5; den_tab[1] = 16'd4; ph_tab[1] = 16'd0;
        ch_tab[2] = 3'd0; num_tab[2] = 16'd1; den_tab[2] = 16'd4; ph_tab[2] = 16'd4;
        ch_tab[3] = 3'd2; num_tab[3] = 16'd1; den_tab[3] = 16'd2; ph_tab[3] = 16'd0;
        for (int r = 0; r < 4; r++) begin
            do_cfg(ch_tab[r], num_tab[r], den_tab[r], ph_tab[r]);
            n_checks += 3;
            if (cfg_err !== 1'b1)   begin n_errors++; $display("FAIL rej_err r=%0d got=%b exp=1", r, cfg_err); end
            if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL rej_ready r=%0d got=%b exp=1", r, cfg_ready); end
            if (locked !== 2'b11)   begin n_errors++; $display("FAIL rej_locked r=%0d got=%b exp=11", r, locked); end
            cycle();
            n_checks++;
            if (cfg_err !== 1'b0)   begin n_errors++; $display("FAIL rej_pulse_len r=%0d got=%b exp=0", r, cfg_err); end
        end
    endtask

    task automatic test_back_to_back();
        int snap;
        int lowcnt;
        snap = cnt0;
        do_cfg(3'd1, 16'd1, 16'd3, 16'd0);
        n_checks += 2;
        if (cfg_ready !== 1'b0) begin n_errors++; $display("FAIL iso_ready got=%b exp=0", cfg_ready); end
        if (locked !== 2'b01)   begin n_errors++; $display("FAIL iso_locked got=%b exp=01", locked); end
        cfg_chan  = 3'd1;
        cfg_num   = 16'd2;
        cfg_den   = 16'd5;
        cfg_phase = 16'd1;
        cfg_valid = 1'b1;
        lowcnt = 0;
        for (int j = 1; j < LC; j++) begin
            cycle();
            if (locked[1] === 1'b0 && cfg_ready === 1'b0) lowcnt++;
        end
        n_checks++;
        if (lowcnt != LC - 1) begin n_errors++; $display("FAIL iso_settle got=%0d exp=%0d", lowcnt, LC - 1); end
        cycle();
        n_checks += 2;
        if (locked[1] !== 1'b1) begin n_errors++; $display("FAIL iso_relock got=%b exp=1", locked[1]); end
        if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL iso_ready_back got=%b exp=1", cfg_ready); end
        cycle();
        cfg_valid = 1'b0;
        n_checks += 2;
        if (cfg_ready !== 1'b0) begin n_errors++; $display("FAIL held_accept_ready got=%b exp=0", cfg_ready); end
        if (locked !== 2'b01)   begin n_errors++; $display("FAIL held_accept_locked got=%b exp=01", locked); end
        cycle();
        cycle();
        n_checks++;
        if (cnt0 - snap != 2) begin n_errors++; $display("FAIL iso_ch0_train got=%0d exp=2", cnt0 - snap); end
        repeat (LC) cycle();
        n_checks++;
        if (locked !== 2'b11) begin n_errors++; $display("FAIL held_lock got=%b exp=11", locked); end
        repeat (20) cycle();
    endtask

    task automatic test_reset_mid_settle();
        int first;
        int n1;
        do_cfg(3'd0, 16'd1, 16'd2, 16'd1);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        cycle();
        n_checks += 4;
        if (cen !== 2'b00)      begin n_errors++; $display("FAIL mid_cen got=%b exp=00", cen); end
        if (locked !== 2'b00)   begin n_errors++; $display("FAIL mid_locked got=%b exp=00", locked); end
        if (cfg_ready !== 1'b0) begin n_errors++; $display("FAIL mid_ready got=%b exp=0", cfg_ready); end
        if (cfg_err !== 1'b0)   begin n_errors++; $display("FAIL mid_err got=%b exp=0", cfg_err); end
        rst = 1'b0;
        repeat (LC - 1) cycle();
        n_checks++;
        if (locked !== 2'b00) begin n_errors++; $display("FAIL mid_prelock got=%b exp=00", locked); end
        cycle();
        n_checks += 2;
        if (locked !== 2'b11)   begin n_errors++; $display("FAIL mid_relock got=%b exp=11", locked); end
        if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL mid_ready_back got=%b exp=1", cfg_ready); end
        first = 0;
        n1    = 0;
        for (int j = 1; j <= 8; j++) begin
            cycle();
            if (cen[1] === 1'b1) n1++;
            if (cen[0] === 1'b1 && first == 0) first = j;
        end
        n_checks += 2;
        if (first != 8) begin n_errors++; $display("FAIL mid_def_ch0 got=%0d exp=8", first); end
        if (n1 != 8)    begin n_errors++; $display("FAIL mid_def_ch1 got=%0d exp=8", n1); end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan  = 3'd0;
        cfg_num   = 16'd0;
        cfg_den   = 16'd0;
        cfg_phase = 16'd0;
        test_reset();
        test_fractional();
        test_phase();
        test_rejects();
        test_back_to_back();
        test_reset_mid_settle();
        @(posedge refclk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Parametrised, multi-channel fractional clock-enable generator; successor to the fixed two-output PLL wrapper.
- Runs entirely in the refclk domain. Each channel emits single-cycle enable pulses at rate refclk * NUM/DEN.
- Each channel has a programmable start phase, a per-channel lock indication and runtime reprogramming through a valid/ready config port.
- Sits beside the PLL. Derives core/video enables from a PLL output without another MMCM/PLL, and lets the core retune rates at run time.

Parameters:
- CHANNELS, 2, number of enable channels (1..8).
- ACC_W, 16, width of NUM, DEN, PHASE and the per-channel accumulator.
- LOCK_CYCLES, 256, settle cycles after reset or reprogramming before locked asserts (>=1).
- DEF_NUM, {16'd1,16'd1}, packed per-channel reset numerators; channel 0 in the LSBs.
- DEF_DEN, {16'd1,16'd8}, packed per-channel reset denominators; defaults give ch0 = 1/8, ch1 = 1/1.

Ports:
- refclk, input, 1, sole clock.
- rst, input, 1, synchronous active-high reset.
- cfg_valid, input, 1, config request.
- cfg_ready, output, 1, config accept; high only in IDLE.
- cfg_chan, input, 3, target channel.
- cfg_num, input, ACC_W, new numerator.
- cfg_den, input, ACC_W, new denominator.
- cfg_phase, input, ACC_W, initial accumulator value.
- cfg_err, output, 1, one-cycle pulse when a request is rejected.
- cen, output, CHANNELS, registered enable pulses.
- locked, output, CHANNELS, per-channel settled flag.

Behaviour:
- Synchronous active-high reset, single clock refclk.
- While rst=1:
  - cen=0, locked=0, cfg_ready=0, cfg_err=0.
  - Every channel loads DEF_NUM/DEF_DEN, acc=0.
  - State=SETTLE with target=all channels; settle counter=LOCK_CYCLES-1.
  - Reset asserted mid-operation aborts any settle/config and restarts this sequence.
- FSM states: IDLE, SETTLE.
  - SETTLE: counter decrements each edge.
  - At the edge where counter==0: the target channel(s) get locked<=1, state<=IDLE, cfg_ready<=1.
  - After reset release, locked[all] is therefore visible high after exactly LOCK_CYCLES edges.
- Handshake: a request is accepted on an edge with cfg_valid=1 and cfg_ready=1. It is validated on that same edge.
- Invalid request: cfg_chan>=CHANNELS, cfg_den==0, cfg_num>cfg_den, or cfg_phase>=cfg_den.
  - cfg_err pulses high for exactly one cycle.
  - No register changes; state stays IDLE; cfg_ready stays 1.
- Valid request:
  - Load num/den/acc<=cfg_phase for channel c; locked[c]<=0, cen[c]<=0.
  - Counter<=LOCK_CYCLES-1, state<=SETTLE with target=c, cfg_ready<=0.
  - Other channels keep running and keep their locked state.
- Accumulation, only for channels with locked=1, every edge:
  - next = acc + num, computed ACC_W+1 bits wide (no overflow).
  - If next >= den: acc<=next-den, cen<=1. Otherwise acc<=next, cen<=0.
  - Accumulation first runs on the edge after locked rises.
- Channels with locked=0 hold acc and drive cen=0.
- num==0 is valid: the channel locks normally and never pulses.
- num==den gives cen=1 every cycle once locked.
- Long-run rate is exact: over any den*k cycles a channel produces exactly num*k pulses.
- cfg_valid while cfg_ready=0 is ignored; the requester must hold it until accepted.
- cfg_valid asserted in the same cycle that SETTLE completes is only accepted on the following edge, when cfg_ready=1.

Test Plan:
- Reset and settle: LOCK_CYCLES=4, hold rst 3 cycles then release → locked=2'b11 after the 4th edge. ch1 then drives cen=1 every cycle. ch0 first pulses on the 8th accumulating edge, then every 8 cycles.
- Fractional rate: program ch0 num=3 den=7 phase=0 → after lock, 3 pulses in every 7 cycles at acc sequence 3,6,2*,5,1*,4,0*. Starred steps pulse. Count = 300 over 700 cycles.
- Phase offset: ch0 num=1 den=4, phase=3 vs phase=0 → phase=3 pulses on the 1st accumulating edge, phase=0 on the 4th. Both then pulse every 4 cycles.
- Rejects: each of cfg_den=0, num=5/den=4, phase=4/den=4, cfg_chan=2 → one-cycle cfg_err, cfg_ready stays 1. cen/locked on all channels unchanged.
- Isolation and backpressure: reprogram ch1 while ch0 runs → ch0 pulse train uninterrupted, locked[1] low for LOCK_CYCLES. cfg_ready=0 throughout. A second cfg_valid held during SETTLE is accepted on the first edge after cfg_ready returns to 1.
- Reset mid-settle: assert rst during SETTLE of ch0 → all outputs go to reset values. Channels return to DEF values and lock LOCK_CYCLES edges after release.
